// File: rtl/lms2rgb_if.sv
// Pixel stream bundle for lms2rgb: an LMS input side and an RGB output side,
// each with its own valid/ready handshake.
// slave  = the converter (consumes LMS, produces RGB).
// master = the environment around it (produces LMS, consumes RGB).
interface lms2rgb_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_L;
  logic [15:0] i_M;
  logic [15:0] i_S;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_R;
  logic [7:0]  o_G;
  logic [7:0]  o_B;

  modport slave (
    input  i_valid, i_L, i_M, i_S, i_ready,
    output o_ready, o_valid, o_R, o_G, o_B
  );

  modport master (
    output i_valid, i_L, i_M, i_S, i_ready,
    input  o_ready, o_valid, o_R, o_G, o_B
  );
endinterface

// File: rtl/lms2rgb.sv
// lms2rgb: inverse colour-space converter, unsigned Q9.7 LMS in, 8-bit RGB out.
// A single signed multiplier is stepped through the nine matrix terms, so a
// pixel takes 9 MAC cycles and one pixel is produced every 11 cycles at best.
// Optional feature: define LMS2RGB_ROUND_EN to round half up before the final
// shift; without it the result is truncated toward minus infinity.
//
// state | meaning
// IDLE  | o_ready=1, waiting for an input pixel
// MAC   | stepping k=0..8 through the coefficient matrix
// OUT   | o_valid=1 with stable RGB until the downstream takes it
module lms2rgb (
  input  logic     i_clk,
  input  logic     i_rst,
  lms2rgb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        lat_l;
  logic [15:0]        lat_m;
  logic [15:0]        lat_s;
  logic [3:0]         k;
  logic signed [35:0] acc;
  logic [7:0]         r_q;
  logic [7:0]         g_q;
  logic [7:0]         b_q;

  logic signed [15:0] coef;
  logic [15:0]        opnd;
  logic signed [32:0] prod;
  logic signed [35:0] acc_sum;
  logic signed [35:0] acc_rnd;
  logic signed [35:0] shifted;
  logic [7:0]         sat;
  logic               accept;
  logic               ch_done;
  logic               last_step;

  // Coefficient and operand for the current step; row = output channel.
  always_comb begin
    coef = 16'sd0;
    opnd = 16'd0;
    case (k)
      4'd0: begin coef =  16'sd18301; opnd = lat_l; end
      4'd1: begin coef = -16'sd14694; opnd = lat_m; end
      4'd2: begin coef =  16'sd489;   opnd = lat_s; end
      4'd3: begin coef = -16'sd4991;  opnd = lat_l; end
      4'd4: begin coef =  16'sd9752;  opnd = lat_m; end
      4'd5: begin coef = -16'sd665;   opnd = lat_s; end
      4'd6: begin coef =  16'sd204;   opnd = lat_l; end
      4'd7: begin coef = -16'sd999;   opnd = lat_m; end
      4'd8: begin coef =  16'sd4934;  opnd = lat_s; end
      default: begin coef = 16'sd0; opnd = 16'd0; end
    endcase
  end

  // Multiply-accumulate, scale from 2^-19 LSB to integer, and clamp to 0..255.
  always_comb begin
    prod    = 33'(coef) * 33'($signed({1'b0, opnd}));
    acc_sum = acc + 36'(prod);
`ifdef LMS2RGB_ROUND_EN
    acc_rnd = acc_sum + 36'sd262144;
`else
    acc_rnd = acc_sum;
`endif
    shifted = acc_rnd >>> 19;
    if (shifted < 36'sd0)
      sat = 8'd0;
    else if (shifted > 36'sd255)
      sat = 8'd255;
    else
      sat = shifted[7:0];
  end

  assign accept    = (state == IDLE) && bus.i_valid;
  assign ch_done   = (k == 4'd2) || (k == 4'd5) || (k == 4'd8);
  assign last_step = (k == 4'd8);

  // State register; reset discards any pixel in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode for the accept / compute / present sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_valid) state_nxt = MAC;
      MAC:     if (last_step)   state_nxt = OUT;
      OUT:     if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch inputs on accept, step the MAC, commit each finished channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_l <= 16'd0;
      lat_m <= 16'd0;
      lat_s <= 16'd0;
      k     <= 4'd0;
      acc   <= 36'sd0;
      r_q   <= 8'd0;
      g_q   <= 8'd0;
      b_q   <= 8'd0;
    end else if (accept) begin
      lat_l <= bus.i_L;
      lat_m <= bus.i_M;
      lat_s <= bus.i_S;
      k     <= 4'd0;
      acc   <= 36'sd0;
    end else if (state == MAC) begin
      k   <= k + 4'd1;
      acc <= ch_done ? 36'sd0 : acc_sum;
      if (k == 4'd2) r_q <= sat;
      if (k == 4'd5) g_q <= sat;
      if (k == 4'd8) b_q <= sat;
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == OUT);
  assign bus.o_R     = r_q;
  assign bus.o_G     = g_q;
  assign bus.o_B     = b_q;

endmodule

// File: tb/tb_lms2rgb.sv
// Self-checking bench for lms2rgb: directed cases plus random pixels checked
// against an integer model of the inverse matrix, scaling and clamp.
module tb_lms2rgb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  lms2rgb_if bus ();

  lms2rgb dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_ch(input int ch, input longint l, input longint m, input longint s);
    longint c[3][3];
    longint acc;
    longint res;
    c[0][0] = 18301;  c[0][1] = -14694; c[0][2] = 489;
    c[1][0] = -4991;  c[1][1] = 9752;   c[1][2] = -665;
    c[2][0] = 204;    c[2][1] = -999;   c[2][2] = 4934;
    acc = c[ch][0] * l + c[ch][1] * m + c[ch][2] * s;
`ifdef LMS2RGB_ROUND_EN
    acc = acc + 262144;
`endif
    res = acc >>> 19;
    if (res < 0) return 8'd0;
    if (res > 255) return 8'd255;
    return res[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] m, input logic [15:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 100), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_L = l;
    bus.i_M = m;
    bus.i_S = s;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Called right after the accept edge; leaves time #1 after the edge where o_valid rose.
  task automatic wait_out(input string tag, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    int n;
    n = 0;
    while (!bus.o_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd9);
    chk({tag, "_R"}, 32'(bus.o_R), 32'(er));
    chk({tag, "_G"}, 32'(bus.o_G), 32'(eg));
    chk({tag, "_B"}, 32'(bus.o_B), 32'(eb));
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.o_ready), 32'd1);
  endtask

  task automatic run_pixel(input string tag, input logic [15:0] l, input logic [15:0] m, input logic [15:0] s);
    send(l, m, s);
    wait_out(tag, ref_ch(0, l, m, s), ref_ch(1, l, m, s), ref_ch(2, l, m, s));
    drain(tag);
  endtask

  initial begin
    logic [7:0]  hr, hg, hb;
    logic [7:0]  wr, wg, wb;
    logic [15:0] rl, rm, rs;
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_L = 16'd0;
    bus.i_M = 16'd0;
    bus.i_S = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_rgb", 32'({bus.o_R, bus.o_G, bus.o_B}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Black pixel.
    send(16'd0, 16'd0, 16'd0);
    wait_out("zero", 8'd0, 8'd0, 8'd0);
    drain("zero");

    // White from the forward stage; G differs between rounding builds.
`ifdef LMS2RGB_ROUND_EN
    wr = 8'd255; wg = 8'd255; wb = 8'd255;
`else
    wr = 8'd255; wg = 8'd254; wb = 8'd255;
`endif
    send(16'd32624, 16'd32616, 16'd32548);
    wait_out("white", wr, wg, wb);
    drain("white");

    // Pure M drives R and B negative and G past 255.
    send(16'd0, 16'd32640, 16'd0);
    wait_out("clamp", 8'd0, 8'd255, 8'd0);
    drain("clamp");

    // Output stall with input activity.
    bus.i_ready = 1'b0;
    rl = 16'd20000; rm = 16'd12000; rs = 16'd9000;
    send(rl, rm, rs);
    hr = ref_ch(0, rl, rm, rs);
    hg = ref_ch(1, rl, rm, rs);
    hb = ref_ch(2, rl, rm, rs);
    wait_out("stall", hr, hg, hb);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.i_valid = $urandom_range(0, 1);
      bus.i_L = 16'($urandom);
      bus.i_M = 16'($urandom);
      bus.i_S = 16'($urandom);
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(bus.o_valid), 32'd1);
      chk("stall_ready", 32'(bus.o_ready), 32'd0);
      chk("stall_rgb", 32'({bus.o_R, bus.o_G, bus.o_B}), 32'({hr, hg, hb}));
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drain("release");

    // Reset in the middle of the MAC sequence, after R has been committed.
    send(16'd32624, 16'd32616, 16'd32548);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd1);
    chk("midrst_rgb", 32'({bus.o_R, bus.o_G, bus.o_B}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_pixel("after_rst", 16'd15000, 16'd14000, 16'd16000);

    // Random pixels, with an occasional output stall.
    for (int i = 0; i < 25; i++) begin
      int stall;
      rl = 16'($urandom);
      rm = 16'($urandom);
      rs = 16'($urandom);
      stall = int'($urandom_range(0, 3));
      bus.i_ready = (stall == 0);
      send(rl, rm, rs);
      wait_out("rand", ref_ch(0, rl, rm, rs), ref_ch(1, rl, rm, rs), ref_ch(2, rl, rm, rs));
      if (stall != 0) begin
        repeat (stall) @(posedge clk);
        #1;
        chk("rand_hold", 32'(bus.o_valid), 32'd1);
        @(negedge clk);
        bus.i_ready = 1'b1;
      end
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
